// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and saturating-counter helpers for the gshare predictor
package bp_pkg;

    localparam int CTR_MAX_BITS = 16;

    // Wide counter container; each instance casts to its own CTR_BITS (limit CTR_MAX_BITS).
    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WR_SET = 2'd0,
        WR_INC = 2'd1,
        WR_DEC = 2'd2
    } wr_op_e;

    function automatic ctr_t ctr_max(input int unsigned bits);
        return ctr_t'((32'd1 << bits) - 32'd1);
    endfunction

    function automatic ctr_t weak_nt(input int unsigned bits);
        return ctr_t'((32'd1 << (bits - 1)) - 32'd1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t v, input int unsigned bits);
        return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/pht_ram.sv
// rtl/pht_ram.sv - pattern history table: registered read, read-modify-write update port
module pht_ram
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 10,
    parameter int CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rd_en_i,
    input  logic [IDX_BITS-1:0] rd_addr_i,
    output logic [CTR_BITS-1:0] rd_data_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_addr_i,
    input  wr_op_e              wr_op_i,
    input  logic [CTR_BITS-1:0] wr_data_i
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [CTR_BITS-1:0] mem_q [DEPTH];
    logic [CTR_BITS-1:0] wr_cur;
    logic [CTR_BITS-1:0] wr_next;
    logic [CTR_BITS-1:0] rd_q;

    assign wr_cur = mem_q[wr_addr_i];

    always_comb begin
        wr_next = wr_data_i;
        case (wr_op_i)
            WR_INC:  wr_next = CTR_BITS'(sat_inc(ctr_t'(wr_cur), CTR_BITS));
            WR_DEC:  wr_next = CTR_BITS'(sat_dec(ctr_t'(wr_cur)));
            default: wr_next = wr_data_i;
        endcase
    end

    // Storage has no reset; the owner sweeps it after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_next;
        end
    end

    // Non-blocking read of the same array gives read-before-write on a shared address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor top; GSHARE_STATS_EN adds update/mispredict counters
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 10,
    parameter int HIST_LEN = 8,
    parameter int CTR_BITS = 2,
    parameter int IDX_LSB  = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                predict_en_i,
    input  logic [31:0]         pred_idx_i,
    output logic                prediction_o,
    output logic                pred_valid_o,
    output logic [HIST_LEN-1:0] pred_hist_o,
    input  logic                update_en_i,
    input  logic [31:0]         idx_i,
    input  logic [HIST_LEN-1:0] upd_hist_i,
    input  logic                br_result_i,
    input  logic                correct_i,
    output logic                ready_o
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]         upd_cnt_o,
    output logic [31:0]         mispred_cnt_o
`endif
);

    state_e                state_q;
    logic [IDX_BITS-1:0]   ptr_q;
    logic                  ready_q;
    logic [HIST_LEN-1:0]   ghr_q;
    logic [HIST_LEN-1:0]   ghr_d;
    logic [HIST_LEN-1:0]   ghr_shift;
    logic [HIST_LEN-1:0]   pred_hist_q;
    logic                  pred_valid_q;

    logic                  accept_pred;
    logic                  accept_upd;
    logic [IDX_BITS-1:0]   pred_index;
    logic [IDX_BITS-1:0]   upd_index;

    logic                  ram_wr_en;
    logic [IDX_BITS-1:0]   ram_wr_addr;
    wr_op_e                ram_wr_op;
    logic [CTR_BITS-1:0]   ram_wr_data;
    logic [CTR_BITS-1:0]   ram_rd_data;

    assign accept_pred = (state_q == READY) && predict_en_i;
    assign accept_upd  = (state_q == READY) && update_en_i;

    assign pred_index = pred_idx_i[IDX_LSB +: IDX_BITS] ^ IDX_BITS'(ghr_q);
    assign upd_index  = idx_i[IDX_LSB +: IDX_BITS] ^ IDX_BITS'(upd_hist_i);

    generate
        if (HIST_LEN == 1) begin : g_hist_one
            assign ghr_shift = br_result_i;
        end else begin : g_hist_multi
            assign ghr_shift = {ghr_q[HIST_LEN-2:0], br_result_i};
        end
    endgenerate

    assign ghr_d = accept_upd ? ghr_shift : ghr_q;

    // The single write port is shared by the init sweep and committed updates.
    assign ram_wr_en   = (state_q == INIT) || accept_upd;
    assign ram_wr_addr = (state_q == INIT) ? ptr_q : upd_index;
    assign ram_wr_op   = (state_q == INIT) ? WR_SET : (br_result_i ? WR_INC : WR_DEC);
    assign ram_wr_data = CTR_BITS'(weak_nt(CTR_BITS));

    pht_ram #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_en_i   (accept_pred),
        .rd_addr_i (pred_index),
        .rd_data_o (ram_rd_data),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_op_i   (ram_wr_op),
        .wr_data_i (ram_wr_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + IDX_BITS'(1);
                    if (ptr_q == '1) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_hist_q  <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= accept_pred;
            if (accept_pred) begin
                pred_hist_q <= ghr_q;
            end
        end
    end

    assign prediction_o = ram_rd_data[CTR_BITS-1];
    assign pred_valid_o = pred_valid_q;
    assign pred_hist_o  = pred_hist_q;
    assign ready_o      = ready_q;

`ifdef GSHARE_STATS_EN
    logic [31:0] upd_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (accept_upd) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            if (!correct_i) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign upd_cnt_o     = upd_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif

    // PC bits outside the index window and the lower counter bits are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{pred_idx_i, idx_i, correct_i, ram_rd_data};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - randomized and directed checks of gshare_predictor against a table model
module tb_gshare_predictor;

    localparam int IDX_BITS = 10;
    localparam int HIST_LEN = 8;
    localparam int CTR_BITS = 2;
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int WEAK_NT  = (1 << (CTR_BITS - 1)) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                predict_en = 1'b0;
    logic [31:0]         pred_idx = '0;
    logic                prediction;
    logic                pred_valid;
    logic [HIST_LEN-1:0] pred_hist;
    logic                update_en = 1'b0;
    logic [31:0]         idx = '0;
    logic [HIST_LEN-1:0] upd_hist = '0;
    logic                br_result = 1'b0;
    logic                correct = 1'b1;
    logic                ready;
`ifdef GSHARE_STATS_EN
    logic [31:0]         upd_cnt;
    logic [31:0]         mispred_cnt;
`endif

    always #5 clk = ~clk;

    gshare_predictor #(
        .IDX_BITS (IDX_BITS),
        .HIST_LEN (HIST_LEN),
        .CTR_BITS (CTR_BITS),
        .IDX_LSB  (0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .predict_en_i  (predict_en),
        .pred_idx_i    (pred_idx),
        .prediction_o  (prediction),
        .pred_valid_o  (pred_valid),
        .pred_hist_o   (pred_hist),
        .update_en_i   (update_en),
        .idx_i         (idx),
        .upd_hist_i    (upd_hist),
        .br_result_i   (br_result),
        .correct_i     (correct),
        .ready_o       (ready)
`ifdef GSHARE_STATS_EN
        ,
        .upd_cnt_o     (upd_cnt),
        .mispred_cnt_o (mispred_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    int          m_pht [ENTRIES];
    int          m_ghr;
    int          m_init;
    bit          m_valid;
    bit          m_pred;
    int          m_hist;
    int unsigned m_upd;
    int unsigned m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ghr = 0; m_init = 0; m_valid = 0; m_pred = 0; m_hist = 0; m_upd = 0; m_mis = 0;
        for (int i = 0; i < ENTRIES; i++) m_pht[i] = WEAK_NT;
    endfunction

    // Model advance for one clock edge given the inputs currently driven.
    function automatic void model_edge();
        int p;
        int u;
        if (!rst_n) return;
        if (m_init < ENTRIES) begin
            m_init++;
            m_valid = 0;
            return;
        end
        m_valid = predict_en;
        if (predict_en) begin
            p = (pred_idx ^ m_ghr) % ENTRIES;
            m_pred = (m_pht[p] > WEAK_NT);
            m_hist = m_ghr;
        end
        if (update_en) begin
            u = (idx ^ upd_hist) % ENTRIES;
            if (br_result) m_pht[u] = (m_pht[u] < CMAX) ? m_pht[u] + 1 : CMAX;
            else           m_pht[u] = (m_pht[u] > 0) ? m_pht[u] - 1 : 0;
            m_ghr = ((m_ghr * 2) + br_result) % (1 << HIST_LEN);
            m_upd++;
            if (!correct) m_mis++;
        end
    endfunction

    task automatic compare_outputs();
        chk("ready", ready, (m_init == ENTRIES));
        chk("pred_valid", pred_valid, m_valid);
        chk("prediction", prediction, m_pred);
        chk("pred_hist", pred_hist, m_hist);
`ifdef GSHARE_STATS_EN
        chk("upd_cnt", upd_cnt, m_upd);
        chk("mispred_cnt", mispred_cnt, m_mis);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_idle();
        predict_en = 0; update_en = 0; correct = 1;
    endtask

    task automatic randomize_inputs();
        predict_en = 1'($urandom_range(0, 1));
        pred_idx   = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 31);
        update_en  = 1'($urandom_range(0, 1));
        idx        = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 31);
        upd_hist   = HIST_LEN'($urandom_range(0, 3));
        br_result  = 1'($urandom_range(0, 1));
        correct    = 1'($urandom_range(0, 1));
    endtask

    task automatic do_predict(input logic [31:0] pc);
        set_idle(); predict_en = 1; pred_idx = pc;
        step();
    endtask

    task automatic do_update(input logic [31:0] a, input logic [HIST_LEN-1:0] h,
                             input logic taken, input logic ok);
        set_idle(); update_en = 1; idx = a; upd_hist = h; br_result = taken; correct = ok;
        step();
    endtask

    task automatic apply_reset(input int low_cycles);
        rst_n = 0;
        model_reset();
        #1;
        chk("reset_async_valid", pred_valid, 1'b0);
        chk("reset_async_ready", ready, 1'b0);
        for (int i = 0; i < low_cycles; i++) begin
            randomize_inputs();
            @(negedge clk);
            compare_outputs();
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic sweep_until_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            randomize_inputs();
            step();
            n++;
        end
        chk("ready_low_cycles", n, ENTRIES);
        set_idle();
    endtask

    initial begin
        model_reset();
        set_idle();
        #2;
        chk("reset_prediction", prediction, 1'b0);
        chk("reset_valid", pred_valid, 1'b0);
        chk("reset_hist", pred_hist, '0);
        chk("reset_ready", ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        sweep_until_ready();

        do_predict(32'h0);
        chk("first_pred", prediction, 1'b0);
        chk("first_hist", pred_hist, 8'h00);

        do_update(32'h4, 8'h00, 1'b1, 1'b1);
        do_update(32'h4, 8'h00, 1'b1, 1'b1);
        do_predict(32'h7);
        chk("trained_pred", prediction, 1'b1);
        chk("trained_hist", pred_hist, 8'h03);
        chk("trained_valid", pred_valid, 1'b1);

        for (int i = 0; i < 5; i++) do_update(32'h10, 8'h00, 1'b1, 1'b1);
        do_update(32'h10, 8'h00, 1'b0, 1'b0);
        do_predict(32'hEE);
        chk("sat_pred", prediction, 1'b1);
        chk("sat_hist", pred_hist, 8'hFE);

        set_idle();
        predict_en = 1; pred_idx = 32'hDE;
        update_en = 1; idx = 32'h20; upd_hist = 8'h00; br_result = 1'b1;
        step();
        chk("rbw_pred", prediction, 1'b0);
        chk("rbw_hist", pred_hist, 8'hFE);
        do_predict(32'hDD);
        chk("rbw_after_pred", prediction, 1'b1);
        chk("rbw_after_hist", pred_hist, 8'hFD);

        set_idle();
        step();
        chk("idle_valid", pred_valid, 1'b0);
        chk("idle_hold_pred", prediction, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        apply_reset(3);
        sweep_until_ready();
        do_predict(32'h10);
        chk("post_reset_pred", prediction, 1'b0);
        chk("post_reset_hist", pred_hist, 8'h00);

`ifdef GSHARE_STATS_EN
        chk("stats_init_upd", upd_cnt, 32'd0);
        chk("stats_init_mis", mispred_cnt, 32'd0);
        do_update(32'h100, 8'h00, 1'b1, 1'b1);
        do_update(32'h100, 8'h00, 1'b0, 1'b0);
        do_update(32'h100, 8'h00, 1'b1, 1'b1);
        chk("stats_upd", upd_cnt, 32'd3);
        chk("stats_mis", mispred_cnt, 32'd1);
`endif

        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            step();
        end

        apply_reset(2);
        for (int i = 0; i < 100; i++) begin
            randomize_inputs();
            step();
        end
        apply_reset(1);
        sweep_until_ready();
        do_predict(32'h4);
        chk("init_reset_pred", prediction, 1'b0);
        chk("init_reset_hist", pred_hist, 8'h00);

        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
